// File: rtl/mesh_core_sink.sv
// Mesh core-port receiving endpoint: buffers router packets in a small FIFO,
// drains them at the core's pace and checks destination and per-source sequence.

package mesh_pkg;
  localparam int DATA_W = 8;
  localparam int ID_W   = 4;

  typedef struct packed {
    logic              valid;
    logic [ID_W-1:0]   dest;
    logic [ID_W-1:0]   source;
    logic [DATA_W-1:0] data;
  } packet_t;
endpackage

module mesh_core_sink
  import mesh_pkg::*;
#(
  parameter int X_NODES    = 4,
  parameter int Y_NODES    = 4,
  parameter int X_LOC      = 0,
  parameter int Y_LOC      = 0,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  packet_t              i_data,
  input  logic                 i_data_val,
  output logic                 o_en,
  input  logic                 i_drain,
  output logic [DATA_W-1:0]    o_pkt_data,
  output logic [ID_W-1:0]      o_pkt_source,
  output logic                 o_pkt_val,
  output logic                 o_seq_err,
  output logic                 o_dest_err,
  output logic [CNT_WIDTH-1:0] o_rx_count,
  output logic [CNT_WIDTH-1:0] o_err_count
);

  localparam int NUM_NODES = X_NODES * Y_NODES;
  localparam int LOCAL_ID  = Y_LOC * X_NODES + X_LOC;
  localparam int PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FILL_W    = $clog2(FIFO_DEPTH + 1);
  localparam int IDX_W     = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;

  localparam logic [FILL_W-1:0] DEPTH_C  = FILL_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [ID_W-1:0]   LOCAL_C  = ID_W'(LOCAL_ID);

  // FIFO storage and control
  packet_t             mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [FILL_W-1:0]   count_q, count_d;
  logic                wr_en, rd_en;
  packet_t             head;

  // Per-source expected sequence numbers
  logic [DATA_W-1:0]   exp_q [NUM_NODES];
  logic [DATA_W-1:0]   exp_d [NUM_NODES];

  // Registered output stage
  logic [DATA_W-1:0]    pkt_data_q, pkt_data_d;
  logic [ID_W-1:0]      pkt_source_q, pkt_source_d;
  logic                 pkt_val_q, pkt_val_d;
  logic                 seq_err_q, seq_err_d;
  logic                 dest_err_q, dest_err_d;
  logic [CNT_WIDTH-1:0] rx_count_q, rx_count_d;
  logic [CNT_WIDTH-1:0] err_count_q, err_count_d;

  // Head checks
  logic                 src_in_range;
  logic [IDX_W-1:0]     src_idx;
  logic                 head_seq_err;
  logic                 head_dest_err;

  // The router's valid bit is redundant with i_data_val.
  logic unused_valid;
  assign unused_valid = i_data.valid;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Enable depends only on the registered fill level.
  assign o_en  = (count_q < DEPTH_C);
  assign wr_en = i_data_val & o_en;
  assign rd_en = i_drain & (count_q != '0);
  assign head  = mem_q[rd_ptr_q];

  assign src_in_range  = (32'(head.source) < NUM_NODES);
  assign src_idx       = IDX_W'(head.source);
  assign head_seq_err  = !src_in_range || (head.data != exp_q[src_idx]);
  assign head_dest_err = (head.dest != LOCAL_C);

  always_comb begin
    wr_ptr_d = wr_en ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = rd_en ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    unique case ({wr_en, rd_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    exp_d        = exp_q;
    pkt_val_d    = 1'b0;
    seq_err_d    = 1'b0;
    dest_err_d   = 1'b0;
    pkt_data_d   = pkt_data_q;
    pkt_source_d = pkt_source_q;
    rx_count_d   = rx_count_q;
    err_count_d  = err_count_q;
    if (rd_en) begin
      pkt_val_d    = 1'b1;
      pkt_data_d   = head.data;
      pkt_source_d = head.source;
      seq_err_d    = head_seq_err;
      dest_err_d   = head_dest_err;
      // Any in-range packet resynchronises its source, even on error.
      if (src_in_range) begin
        exp_d[src_idx] = head.data + 1'b1;
      end
      if (rx_count_q != '1) begin
        rx_count_d = rx_count_q + 1'b1;
      end
      if ((head_seq_err || head_dest_err) && (err_count_q != '1)) begin
        err_count_d = err_count_q + 1'b1;
      end
    end
  end

  // NOTE: payload storage has no reset; an empty FIFO is defined by count/pointers alone.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= i_data;
    end
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      pkt_val_q    <= 1'b0;
      seq_err_q    <= 1'b0;
      dest_err_q   <= 1'b0;
      pkt_data_q   <= '0;
      pkt_source_q <= '0;
      rx_count_q   <= '0;
      err_count_q  <= '0;
      for (int s = 0; s < NUM_NODES; s++) begin
        exp_q[s] <= DATA_W'(1);
      end
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      pkt_val_q    <= pkt_val_d;
      seq_err_q    <= seq_err_d;
      dest_err_q   <= dest_err_d;
      pkt_data_q   <= pkt_data_d;
      pkt_source_q <= pkt_source_d;
      rx_count_q   <= rx_count_d;
      err_count_q  <= err_count_d;
      exp_q        <= exp_d;
    end
  end

  assign o_pkt_data   = pkt_data_q;
  assign o_pkt_source = pkt_source_q;
  assign o_pkt_val    = pkt_val_q;
  assign o_seq_err    = seq_err_q;
  assign o_dest_err   = dest_err_q;
  assign o_rx_count   = rx_count_q;
  assign o_err_count  = err_count_q;

endmodule

// File: tb/tb_mesh_core_sink.sv
// Directed bench for mesh_core_sink: in-order delivery, back-pressure,
// sequence/destination errors and asynchronous reset.

module tb_mesh_core_sink;
  import mesh_pkg::*;

  logic                 clk;
  logic                 reset_n;
  packet_t              i_data;
  logic                 i_data_val;
  logic                 o_en;
  logic                 i_drain;
  logic [DATA_W-1:0]    o_pkt_data;
  logic [ID_W-1:0]      o_pkt_source;
  logic                 o_pkt_val;
  logic                 o_seq_err;
  logic                 o_dest_err;
  logic [15:0]          o_rx_count;
  logic [15:0]          o_err_count;

  int n_checks;
  int n_fail;

  mesh_core_sink #(
    .X_NODES(4), .Y_NODES(4), .X_LOC(0), .Y_LOC(0),
    .FIFO_DEPTH(4), .CNT_WIDTH(16)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .i_data(i_data),
    .i_data_val(i_data_val),
    .o_en(o_en),
    .i_drain(i_drain),
    .o_pkt_data(o_pkt_data),
    .o_pkt_source(o_pkt_source),
    .o_pkt_val(o_pkt_val),
    .o_seq_err(o_seq_err),
    .o_dest_err(o_dest_err),
    .o_rx_count(o_rx_count),
    .o_err_count(o_err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Advance past one rising edge; outputs are settled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic packet_t mk(input int dest, input int src, input int data);
    packet_t p;
    p.valid  = 1'b1;
    p.dest   = 4'(dest);
    p.source = 4'(src);
    p.data   = 8'(data);
    return p;
  endfunction

  task automatic check_out(input string tag, input int data, input int src,
                           input bit seq_err, input bit dest_err);
    check({tag, ".val"}, 32'(o_pkt_val), 32'd1);
    check({tag, ".data"}, 32'(o_pkt_data), 32'(data));
    check({tag, ".src"}, 32'(o_pkt_source), 32'(src));
    check({tag, ".seq_err"}, 32'(o_seq_err), 32'(seq_err));
    check({tag, ".dest_err"}, 32'(o_dest_err), 32'(dest_err));
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    reset_n    = 1'b0;
    i_data     = '0;
    i_data_val = 1'b0;
    i_drain    = 1'b0;
    #12 reset_n = 1'b1;
    #1;

    // Reset state
    check("rst.en", 32'(o_en), 32'd1);
    check("rst.val", 32'(o_pkt_val), 32'd0);
    check("rst.seq", 32'(o_seq_err), 32'd0);
    check("rst.dest", 32'(o_dest_err), 32'd0);
    check("rst.data", 32'(o_pkt_data), 32'd0);
    check("rst.src", 32'(o_pkt_source), 32'd0);
    check("rst.rx", 32'(o_rx_count), 32'd0);
    check("rst.err", 32'(o_err_count), 32'd0);

    // 1: source 2 streams data 1,2,3 with drain held
    i_drain = 1'b1; i_data_val = 1'b1; i_data = mk(0, 2, 1);
    tick();
    check("t1.no_bypass", 32'(o_pkt_val), 32'd0);
    i_data = mk(0, 2, 2);
    tick();
    check_out("t1.p1", 1, 2, 0, 0);
    i_data = mk(0, 2, 3);
    tick();
    check_out("t1.p2", 2, 2, 0, 0);
    i_data_val = 1'b0;
    tick();
    check_out("t1.p3", 3, 2, 0, 0);
    tick();
    check("t1.idle_val", 32'(o_pkt_val), 32'd0);
    check("t1.hold_data", 32'(o_pkt_data), 32'd3);
    check("t1.rx", 32'(o_rx_count), 32'd3);
    check("t1.err", 32'(o_err_count), 32'd0);

    // 2: single-packet latency, o_en stays high
    i_data_val = 1'b1; i_data = mk(0, 3, 1);
    tick();
    check("t2.en_n", 32'(o_en), 32'd1);
    check("t2.val_n", 32'(o_pkt_val), 32'd0);
    i_data_val = 1'b0;
    tick();
    check("t2.en_n1", 32'(o_en), 32'd1);
    check_out("t2.p", 1, 3, 0, 0);
    tick();
    check("t2.val_after", 32'(o_pkt_val), 32'd0);
    check("t2.rx", 32'(o_rx_count), 32'd4);

    // 3: back-pressure, source 0 data 1..5 with drain low
    i_drain = 1'b0; i_data_val = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      i_data = mk(0, 0, k);
      tick();
      check("t3.en_fill", 32'(o_en), (k < 4) ? 32'd1 : 32'd0);
    end
    i_data = mk(0, 0, 5);
    tick();
    check("t3.full_en", 32'(o_en), 32'd0);
    check("t3.full_val", 32'(o_pkt_val), 32'd0);
    i_drain = 1'b1;
    #1;
    check("t3.en_comb", 32'(o_en), 32'd0);
    tick();
    check("t3.en_after_read", 32'(o_en), 32'd1);
    check_out("t3.p1", 1, 0, 0, 0);
    i_drain = 1'b0;
    tick();
    check("t3.refull_en", 32'(o_en), 32'd0);
    check("t3.refull_val", 32'(o_pkt_val), 32'd0);
    i_data_val = 1'b0; i_drain = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      tick();
      check_out("t3.drain", k, 0, 0, 0);
    end
    tick();
    check("t3.empty_val", 32'(o_pkt_val), 32'd0);
    check("t3.rx", 32'(o_rx_count), 32'd9);
    check("t3.err", 32'(o_err_count), 32'd0);

    // 4: source 1 sends 1,2,5,6 -> only 5 is a sequence error
    i_data_val = 1'b1; i_data = mk(0, 1, 1);
    tick();
    i_data = mk(0, 1, 2);
    tick();
    check_out("t4.p1", 1, 1, 0, 0);
    i_data = mk(0, 1, 5);
    tick();
    check_out("t4.p2", 2, 1, 0, 0);
    i_data = mk(0, 1, 6);
    tick();
    check_out("t4.p5", 5, 1, 1, 0);
    check("t4.err_on5", 32'(o_err_count), 32'd1);
    i_data_val = 1'b0;
    tick();
    check_out("t4.p6", 6, 1, 0, 0);
    tick();
    check("t4.rx", 32'(o_rx_count), 32'd13);
    check("t4.err", 32'(o_err_count), 32'd1);

    // 5: wrong destination with correct sequence (source 2 expects 4)
    i_data_val = 1'b1; i_data = mk(7, 2, 4);
    tick();
    i_data_val = 1'b0;
    tick();
    check_out("t5.dest", 4, 2, 0, 1);
    check("t5.err", 32'(o_err_count), 32'd2);
    // Both errors on one packet count once (source 2 now expects 5)
    i_data_val = 1'b1; i_data = mk(5, 2, 9);
    tick();
    i_data_val = 1'b0;
    tick();
    check_out("t5.both", 9, 2, 1, 1);
    check("t5.err_once", 32'(o_err_count), 32'd3);
    check("t5.rx", 32'(o_rx_count), 32'd15);
    tick();

    // 6: asynchronous reset with two packets buffered
    i_drain = 1'b0; i_data_val = 1'b1; i_data = mk(0, 0, 6);
    tick();
    i_data = mk(0, 0, 7);
    tick();
    i_data_val = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("t6.en", 32'(o_en), 32'd1);
    check("t6.rx", 32'(o_rx_count), 32'd0);
    check("t6.err", 32'(o_err_count), 32'd0);
    check("t6.val", 32'(o_pkt_val), 32'd0);
    check("t6.data", 32'(o_pkt_data), 32'd0);
    #2 reset_n = 1'b1;
    i_drain = 1'b1;
    tick();
    check("t6.flushed1", 32'(o_pkt_val), 32'd0);
    tick();
    check("t6.flushed2", 32'(o_pkt_val), 32'd0);
    i_data_val = 1'b1; i_data = mk(0, 0, 1);
    tick();
    i_data_val = 1'b0;
    tick();
    check_out("t6.fresh", 1, 0, 0, 0);
    check("t6.rx_after", 32'(o_rx_count), 32'd1);
    check("t6.err_after", 32'(o_err_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
